// File: rtl/mac_dot_accum.sv
// Streaming dot-product MAC: out = c + sum(a*b) over a vector framed by in_last.
// Stage 1 multiplies on accept; stage 2 accumulates with overflow detection and optional clamp.
module mac_dot_accum #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ACC_WIDTH  = 24,
    parameter bit          SIGNED     = 1'b1,
    parameter bit          SATURATE   = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_a,
    input  logic [DATA_WIDTH-1:0] in_b,
    input  logic [DATA_WIDTH-1:0] in_c,
    input  logic                  in_last,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [ACC_WIDTH-1:0]  out_data,
    output logic                  out_ovf
);
    localparam int unsigned PW = 2 * DATA_WIDTH;
    localparam int unsigned SW = ACC_WIDTH + 1;
    localparam logic [ACC_WIDTH-1:0] SMAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    localparam logic [ACC_WIDTH-1:0] SMIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

    typedef enum logic {StIdle, StAccum} state_e;
    state_e state_q, state_d;

    logic                 stall;
    logic                 in_fire;
    logic                 s1_valid_q, s1_valid_d;
    logic                 s1_last_q, s1_last_d;
    logic [PW-1:0]        s1_prod_q, s1_prod_d;
    logic [ACC_WIDTH-1:0] s1_c_q, s1_c_d;
    logic [ACC_WIDTH-1:0] acc_q, acc_d;
    logic                 ovf_q, ovf_d;
    logic                 out_valid_q, out_valid_d;
    logic [ACC_WIDTH-1:0] out_data_q, out_data_d;
    logic                 out_ovf_q, out_ovf_d;

    logic [PW-1:0]        a_ext, b_ext;
    logic [ACC_WIDTH-1:0] base;
    logic [SW-1:0]        base_w, prod_w, sum_w;
    logic                 ovf_now;
    logic [ACC_WIDTH-1:0] res;

    assign stall     = out_valid_q && !out_ready;
    assign in_ready  = !stall && !reset;
    assign in_fire   = in_valid && in_ready;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_ovf   = out_ovf_q;

    // Stage 1: operands extended to the product width so one multiplier serves both modes.
    always_comb begin
        if (SIGNED) begin
            a_ext  = PW'($signed(in_a));
            b_ext  = PW'($signed(in_b));
            s1_c_d = ACC_WIDTH'($signed(in_c));
        end else begin
            a_ext  = PW'(in_a);
            b_ext  = PW'(in_b);
            s1_c_d = ACC_WIDTH'(in_c);
        end
        s1_prod_d  = a_ext * b_ext;
        s1_valid_d = in_fire;
        s1_last_d  = in_last;
    end

    // Stage 2 arithmetic: one guard bit above the accumulator exposes overflow.
    always_comb begin
        base = (state_q == StIdle) ? s1_c_q : acc_q;
        if (SIGNED) begin
            base_w  = SW'($signed(base));
            prod_w  = SW'($signed(s1_prod_q));
            sum_w   = base_w + prod_w;
            ovf_now = sum_w[SW-1] ^ sum_w[SW-2];
        end else begin
            base_w  = SW'(base);
            prod_w  = SW'(s1_prod_q);
            sum_w   = base_w + prod_w;
            ovf_now = sum_w[SW-1];
        end
        res = sum_w[ACC_WIDTH-1:0];
        if (SATURATE && ovf_now) begin
            if (SIGNED) begin
                res = sum_w[SW-1] ? SMIN : SMAX;
            end else begin
                res = '1;
            end
        end
    end

    // FSM next state: a vector stays open until its last beat reaches stage 2.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (s1_valid_q && !s1_last_q) state_d = StAccum;
            StAccum: if (s1_valid_q && s1_last_q)  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Accumulator, sticky overflow and result register updates.
    always_comb begin
        acc_d       = acc_q;
        ovf_d       = ovf_q;
        out_valid_d = out_valid_q && !out_ready;
        out_data_d  = out_data_q;
        out_ovf_d   = out_ovf_q;
        if (s1_valid_q) begin
            acc_d = res;
            ovf_d = (state_q == StIdle) ? ovf_now : (ovf_q | ovf_now);
            if (s1_last_q) begin
                out_valid_d = 1'b1;
                out_data_d  = res;
                out_ovf_d   = ovf_d;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
        end else if (!stall) begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid_q  <= 1'b0;
            s1_last_q   <= 1'b0;
            s1_prod_q   <= '0;
            s1_c_q      <= '0;
            acc_q       <= '0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_ovf_q   <= 1'b0;
        end else if (!stall) begin
            s1_valid_q  <= s1_valid_d;
            s1_last_q   <= s1_last_d;
            s1_prod_q   <= s1_prod_d;
            s1_c_q      <= s1_c_d;
            acc_q       <= acc_d;
            ovf_q       <= ovf_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_ovf_q   <= out_ovf_d;
        end
    end

endmodule

// File: doc/mac_dot_accum.md
Name: mac_dot_accum

Overview:
Streaming multiply-accumulate engine. It computes dot products of variable-length vectors: out = c + sum(a[i]*b[i]), with optional signed arithmetic and saturation. Operands arrive one pair per beat over a valid/ready handshake, and in_last marks the final beat of each vector. It is the parametrised successor of the single-cycle mac, intended for filter and matrix datapaths.

Parameters:
DATA_WIDTH, 8, width of a, b and c operands
ACC_WIDTH, 24, accumulator and result width; must be >= 2*DATA_WIDTH
SIGNED, 1, 1 = two's-complement operands and result; 0 = unsigned
SATURATE, 1, 1 = clamp the result on overflow; 0 = wrap modulo 2^ACC_WIDTH

Ports:
clk  input  1  clock; all logic on the rising edge
reset  input  1  synchronous, active-high reset
in_valid  input  1  operand beat valid
in_ready  output  1  block can accept a beat this cycle
in_a  input  DATA_WIDTH  multiplicand
in_b  input  DATA_WIDTH  multiplier
in_c  input  DATA_WIDTH  bias; sampled only on the first beat of a vector
in_last  input  1  beat is the last of the vector
out_valid  output  1  result available
out_ready  input  1  downstream accepts the result
out_data  output  ACC_WIDTH  dot-product result
out_ovf  output  1  overflow occurred in this vector (with SATURATE=1, the result was clamped)

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (reset).
- Handshake:
  - An input beat transfers when in_valid && in_ready.
  - The result transfers when out_valid && out_ready.
  - Define stall = out_valid && !out_ready.
  - in_ready = !stall && !reset.
  - The whole pipeline freezes while stall is high; no register changes.
- Pipeline, with the accept edge called E0:
  - Stage 1 (E0): registers product = in_a*in_b (2*DATA_WIDTH bits, sign- or zero-extended per SIGNED), plus first/last flags and the extended in_c.
  - Stage 2 (E0+1): performs the accumulate.
  - Latency: a last beat accepted on E0 produces out_valid=1 after E0+1. A single-beat vector therefore has 2-cycle latency.
- Accumulate state machine, 2 states:
  - IDLE (no vector open): the next stage-1 beat is first.
    - acc <= ext(c) + product.
    - Go to ACCUM unless that beat is last.
  - ACCUM: acc <= acc + product.
    - Return to IDLE on the last beat.
  - On a last beat, out_data is loaded with the final sum, out_valid is set, and the ovf flag for that vector is loaded into out_ovf.
  - acc clears only by reload on the next first beat.
- Arithmetic:
  - All sums are computed at ACC_WIDTH+1 bits to detect overflow.
  - Signed overflow: the result lies outside [-2^(ACC_WIDTH-1), 2^(ACC_WIDTH-1)-1].
  - Unsigned overflow: the result is >= 2^ACC_WIDTH.
  - SATURATE=1: clamp acc to the nearest bound. The sticky vector ovf flag is set and stays set until the next first beat.
  - SATURATE=0: acc wraps; ovf is still reported.
- Output holding: out_data and out_ovf are stable while out_valid && !out_ready.
  - out_valid clears on the transfer edge unless a new last beat completes on the same edge. In that case out_valid stays 1 and out_data updates (back-to-back results).
- Bubbles: in_valid=0 mid-vector inserts idle cycles and does not change acc. Vectors have unbounded length.
- Reset:
  - out_valid=0, out_data=0, out_ovf=0, in_ready=0 during reset.
  - State=IDLE, acc=0, stage-1 valid=0.
  - Reset mid-vector discards the partial sum. The next beat after reset is a first beat.

Test Plan:
- Signed, SATURATE=1: a={1,2,3}, b={4,5,6}, c=10 (c on beat 0), last on beat 2, out_ready=1 -> one out_valid pulse, out_data=42, out_ovf=0, 2 cycles after the last accept.
- Single-beat vectors back-to-back: (a=-3,b=7,c=1,last) then (a=2,b=2,c=0,last) on consecutive cycles -> out_data=-20, then 4 on consecutive cycles, no bubble.
- Saturation with ACC_WIDTH=16, signed: a=b=-128 twice, c=0 -> out_data=32767, out_ovf=1. Next vector a=1,b=1,c=0 -> out_data=1, out_ovf=0.
- Unsigned wrap with SIGNED=0, SATURATE=0, ACC_WIDTH=16: a=b=255 twice, c=0 -> out_data=(130050 mod 65536)=64514, out_ovf=1.
- Backpressure: hold out_ready=0 for 5 cycles after a result -> in_ready=0, out_data stable, the queued beat is not lost. Release -> the result transfers once, and the following vector's sum is correct.
- Reset mid-vector after 2 of 4 beats, then a=5,b=5,c=0,last -> out_data=25, no stale output during or after reset.
